// File: rtl/cpu_send_ctrl.sv
// Pseudo-random word sender: each LFSR word is held on outDATA_cpu while outSEND_cpu is high, until acked.
// No ack within TIMEOUT cycles gives a 1-cycle retry; after MAX_RETRY retries it locks in ERROR until reset.
module cpu_send_ctrl #(
   parameter int unsigned DATA_W    = 32,
   parameter logic [31:0] SEED      = 32'h0000_0001,
   parameter int unsigned GAP       = 1,
   parameter int unsigned TIMEOUT   = 15,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic              clk_cpu,
   input  logic              rst_cpu,
   input  logic              en_cpu,
   input  logic              inACK_cpu,
   output logic              outSEND_cpu,
   output logic [DATA_W-1:0] outDATA_cpu,
   output logic [15:0]       outCOUNT_cpu,
   output logic              outERR_cpu
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP,
      ST_RETRY,
      ST_ERROR
   } state_t;

   // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
   localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);
   localparam logic [7:0]  GAP_LAST  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

   state_t      state_q, state_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic [15:0] count_q, count_d;
   logic        err_q, err_d;
   logic [3:0]  retry_q, retry_d;
   logic [7:0]  timer_q, timer_d;
   logic [7:0]  gap_q, gap_d;
   logic [31:0] lfsr_next;

   assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

   always_ff @(posedge clk_cpu or posedge rst_cpu) begin
      if (rst_cpu) begin
         state_q <= ST_IDLE;
         lfsr_q  <= SEED_EFF;
         count_q <= 16'd0;
         err_q   <= 1'b0;
         retry_q <= 4'd0;
         timer_q <= 8'd0;
         gap_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         count_q <= count_d;
         err_q   <= err_d;
         retry_q <= retry_d;
         timer_q <= timer_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      count_d = count_q;
      err_d   = err_q;
      retry_d = retry_q;
      timer_d = timer_q;
      gap_d   = gap_q;
      case (state_q)
         ST_IDLE: begin
            if (en_cpu) begin
               state_d = ST_SEND;
               timer_d = 8'd0;
            end
         end
         ST_SEND: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (inACK_cpu) begin
               lfsr_d  = lfsr_next;
               count_d = count_q + 16'd1;
               retry_d = 4'd0;
               timer_d = 8'd0;
               gap_d   = 8'd0;
               if (GAP > 0)     state_d = ST_GAP;
               else if (en_cpu) state_d = ST_SEND;
               else             state_d = ST_IDLE;
            end else if (timer_q == TO_LAST) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_RETRY;
                  retry_d = retry_q + 4'd1;
               end
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = en_cpu ? ST_SEND : ST_IDLE;
               timer_d = 8'd0;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         ST_RETRY: begin
            state_d = ST_SEND;
            timer_d = 8'd0;
         end
         ST_ERROR: begin
            err_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Decoded straight from the state register so an async reset drops it immediately.
   assign outSEND_cpu  = (state_q == ST_SEND);
   assign outDATA_cpu  = lfsr_q[DATA_W-1:0];
   assign outCOUNT_cpu = count_q;
   assign outERR_cpu   = err_q;

endmodule
